// File: rtl/demux_1_n_seq_pkg.sv
// Shared constants and the round-robin pointer wrap helper for demux_1_n_seq.
package demux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Next round-robin channel index, wrapping from n-1 back to 0.
    function automatic int unsigned rr_wrap(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/demux_1_n_seq_chan_reg.sv
// One-entry valid/ready holding register for a single demux output channel.
// With DEMUX_1_N_SEQ_IDLE_ZERO_EN defined, data_o reads 0 while the channel is empty.
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load wins over a drain, so load+drain in one cycle keeps the channel full.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the data register is reset as well because Y must read 0 after reset.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
`ifdef DEMUX_1_N_SEQ_IDLE_ZERO_EN
    assign data_o = valid_q ? data_q : '0;
`else
    assign data_o = data_q;
`endif

endmodule

// File: rtl/demux_1_n_seq.sv
// Registered 1:N stream demux with direct or round-robin channel selection.
// Optional idle-output gating: DEMUX_1_N_SEQ_IDLE_ZERO_EN (implemented in demux_chan_reg).
module demux_1_n_seq
    import demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   D,
    input  logic               D_valid,
    output logic               D_ready,
    input  logic [SELW-1:0]    S,
    input  logic               mode,
    output logic [N*WIDTH-1:0] Y,
    output logic [N-1:0]       Y_valid,
    input  logic [N-1:0]       Y_ready,
    output logic [SELW-1:0]    rr_ptr,
    output logic               sel_err
);

    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0] tgt;
    logic            in_range;
    logic            tgt_free;
    logic            accept;
    logic [N-1:0]    load;
    logic            sel_err_q;

    // An out-of-range target matches no channel, so it stays "free" and the beat is dropped.
    always_comb begin
        tgt      = (mode == MODE_RR) ? rr_ptr_q : S;
        in_range = (32'(tgt) < N);
        tgt_free = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (tgt == SELW'(k)) tgt_free = !Y_valid[k] || Y_ready[k];
        end
        accept = D_valid && tgt_free;
        load   = '0;
        for (int k = 0; k < N; k++) begin
            load[k] = accept && (tgt == SELW'(k));
        end
        rr_ptr_d = rr_ptr_q;
        if (accept && (mode == MODE_RR)) rr_ptr_d = SELW'(rr_wrap(32'(rr_ptr_q), N));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            sel_err_q <= accept && !in_range;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        demux_chan_reg #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[k]),
            .d_i     (D),
            .ready_i (Y_ready[k]),
            .valid_o (Y_valid[k]),
            .data_o  (Y[k*WIDTH +: WIDTH])
        );
    end

    assign D_ready = tgt_free;
    assign rr_ptr  = rr_ptr_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demux_1_n_seq.sv
// Self-checking bench for demux_1_n_seq: N=8 instance against a behavioural model, N=5 drop-path checks.
module tb_demux_1_n_seq;

    localparam int N = 8;

    logic        clk, rst;
    logic [7:0]  d;
    logic        d_valid, d_ready;
    logic [2:0]  s;
    logic        mode;
    logic [63:0] y;
    logic [7:0]  y_valid, y_ready;
    logic [2:0]  rr_ptr;
    logic        sel_err;

    logic [7:0]  d5;
    logic        d5_valid, d5_ready;
    logic [2:0]  s5;
    logic        mode5;
    logic [39:0] y5;
    logic [4:0]  y5_valid, y5_ready;
    logic [2:0]  rr5;
    logic        sel_err5;

    int tests = 0;
    int fails = 0;

    bit         mv[N];
    logic [7:0] md[N];
    int         mptr;
    bit         msel;

    demux_1_n_seq #(.WIDTH(8), .N(8)) dut (
        .clk(clk), .rst(rst), .D(d), .D_valid(d_valid), .D_ready(d_ready),
        .S(s), .mode(mode), .Y(y), .Y_valid(y_valid), .Y_ready(y_ready),
        .rr_ptr(rr_ptr), .sel_err(sel_err)
    );

    demux_1_n_seq #(.WIDTH(8), .N(5)) dut5 (
        .clk(clk), .rst(rst), .D(d5), .D_valid(d5_valid), .D_ready(d5_ready),
        .S(s5), .mode(mode5), .Y(y5), .Y_valid(y5_valid), .Y_ready(y5_ready),
        .rr_ptr(rr5), .sel_err(sel_err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mv[k] = 1'b0;
            md[k] = 8'h00;
        end
        mptr = 0;
        msel = 1'b0;
    endtask

    function automatic int model_tgt();
        return mode ? mptr : int'(s);
    endfunction

    function automatic bit model_ready();
        int t;
        t = model_tgt();
        if (t >= N) return 1'b1;
        return !mv[t] || y_ready[t];
    endfunction

    // One clock edge of the channel bank: drains, then at most one load, then pointer step.
    task automatic model_step();
        int t;
        bit acc;
        t   = model_tgt();
        acc = d_valid && model_ready();
        for (int k = 0; k < N; k++) if (mv[k] && y_ready[k]) mv[k] = 1'b0;
        msel = acc && (t >= N);
        if (acc && t < N) begin
            mv[t] = 1'b1;
            md[t] = d;
        end
        if (acc && mode) mptr = (mptr + 1) % N;
    endtask

    always @(posedge clk) if (!rst) model_step();

    always @(negedge clk) begin : cmp
        logic [63:0] ey;
        logic [7:0]  ev;
        for (int k = 0; k < N; k++) begin
            ev[k] = mv[k];
`ifdef DEMUX_1_N_SEQ_IDLE_ZERO_EN
            ey[k*8 +: 8] = mv[k] ? md[k] : 8'h00;
`else
            ey[k*8 +: 8] = md[k];
`endif
        end
        check("d_ready", 64'(d_ready), 64'(model_ready()));
        check("y_valid", 64'(y_valid), 64'(ev));
        check("y",       y,            ey);
        check("rr_ptr",  64'(rr_ptr),  64'(mptr));
        check("sel_err", 64'(sel_err), 64'(msel));
    end

    task automatic cyc(input bit v, input logic [7:0] dd, input int ss, input bit m, input logic [7:0] yr);
        @(posedge clk);
        #2;
        d_valid = v;
        d       = dd;
        s       = 3'(ss);
        mode    = m;
        y_ready = yr;
        #1;
    endtask

    initial begin
        logic [7:0] exp_idle;
        d = 0; d_valid = 0; s = 0; mode = 0; y_ready = '1;
        d5 = 0; d5_valid = 0; s5 = 0; mode5 = 0; y5_ready = '1;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_y_valid", 64'(y_valid), 64'h0);
        check("rst_y",       y,            64'h0);
        check("rst_rr_ptr",  64'(rr_ptr),  64'h0);
        check("rst_d_ready", 64'(d_ready), 64'h1);
        @(posedge clk); #2; rst = 1'b0;

        // Direct mode, all consumers ready: one-hot Y_valid one cycle after each beat.
        for (int i = 0; i <= 8; i++) begin
            cyc(i < 8, 8'hA5, i % 8, 1'b0, 8'hFF);
            if (i > 0) begin
                check("dir_y_valid", 64'(y_valid), 64'(8'd1 << (i - 1)));
                check("dir_y",       64'(y[(i-1)*8 +: 8]), 64'hA5);
            end
            if (i < 8) check("dir_d_ready", 64'(d_ready), 64'h1);
        end

        // Backpressure on channel 3.
        cyc(1, 8'h11, 3, 0, 8'hF7);
        cyc(1, 8'h22, 3, 0, 8'hF7);
        check("bp_held_y",  64'(y[31:24]), 64'h11);
        check("bp_d_ready", 64'(d_ready),  64'h0);
        cyc(1, 8'h22, 3, 0, 8'hF7);
        check("bp_still_held", 64'(y[31:24]), 64'h11);
        cyc(1, 8'h22, 3, 0, 8'hFF);
        check("bp_release_ready", 64'(d_ready), 64'h1);
        cyc(0, 8'h00, 3, 0, 8'hFF);
        check("bp_second_valid", 64'(y_valid[3]), 64'h1);
        check("bp_second_y",     64'(y[31:24]),   64'h22);

        // Round-robin, channel 1 stalled from beat 1 onward.
        for (int i = 0; i < 9; i++) begin
            cyc(1, 8'(i), 0, 1, 8'hFD);
            if (i > 0 && (i - 1) % 8 != 1) check("rr_land", 64'(y[((i-1)%8)*8 +: 8]), 64'(i - 1));
        end
        cyc(1, 8'd9, 0, 1, 8'hFD);
        check("rr_ptr_9",      64'(rr_ptr),  64'h1);
        check("rr_stall_rdy",  64'(d_ready), 64'h0);
        cyc(1, 8'd9, 0, 1, 8'hFD);
        check("rr_stall_hold", 64'(rr_ptr),  64'h1);
        cyc(1, 8'd9, 0, 1, 8'hFF);
        check("rr_resume_rdy", 64'(d_ready), 64'h1);
        cyc(0, 8'd0, 0, 1, 8'hFF);
        check("rr_ptr_end", 64'(rr_ptr),   64'h2);
        check("rr_ch1_y",   64'(y[15:8]),  64'h9);

        // Fill channels 2 and 5 with pointer at 4, then reset mid-transfer.
        cyc(1, 8'h20, 0, 1, 8'hDB);
        cyc(1, 8'h30, 0, 1, 8'hDB);
        cyc(1, 8'h50, 5, 0, 8'hDB);
        cyc(0, 8'h00, 0, 0, 8'hDB);
        check("pre_rst_valid", 64'(y_valid), 64'h24);
        check("pre_rst_ptr",   64'(rr_ptr),  64'h4);
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_valid", 64'(y_valid), 64'h0);
        check("mid_rst_y",     y,            64'h0);
        check("mid_rst_ptr",   64'(rr_ptr),  64'h0);
        @(posedge clk); #2; rst = 1'b0;

        // Idle-channel data after drain.
        cyc(1, 8'h5C, 2, 0, 8'hFF);
        cyc(0, 8'h00, 2, 0, 8'hFF);
        cyc(0, 8'h00, 2, 0, 8'hFF);
`ifdef DEMUX_1_N_SEQ_IDLE_ZERO_EN
        exp_idle = 8'h00;
`else
        exp_idle = 8'h5C;
`endif
        check("idle_y2", 64'(y[23:16]), 64'(exp_idle));

        // N=5 drop path and one in-range beat.
        @(posedge clk); #2;
        d5_valid = 1; d5_s_set: s5 = 3'd6; d5 = 8'h77;
        #1;
        check("n5_drop_ready", 64'(d5_ready), 64'h1);
        @(posedge clk); #2;
        d5_valid = 1; s5 = 3'd4; d5 = 8'h3C;
        #1;
        check("n5_sel_err",   64'(sel_err5), 64'h1);
        check("n5_no_valid",  64'(y5_valid), 64'h0);
        @(posedge clk); #2;
        d5_valid = 0;
        #1;
        check("n5_sel_err_off", 64'(sel_err5),   64'h0);
        check("n5_load_valid",  64'(y5_valid),   64'h10);
        check("n5_load_y",      64'(y5[39:32]),  64'h3C);
        check("n5_ptr_hold",    64'(rr5),        64'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom), 8'($urandom), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0), 8'($urandom | $urandom));
        end
        cyc(0, 8'h00, 0, 0, 8'hFF);
        cyc(0, 8'h00, 0, 0, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
